// File: rtl/binary_search_ctrl_pkg.sv
// Shared definitions for the number-guessing controller.
// Covers state encodings, the initial interval bounds and the floor-midpoint helper.
package binary_search_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ASK  = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_t;

    localparam logic [7:0] INIT_LO    = 8'd0;
    localparam logic [7:0] INIT_HI    = 8'd255;
    localparam logic [7:0] INIT_GUESS = 8'd127;

    // The sum needs one extra bit so that (255 + 255) still halves correctly.
    function automatic logic [7:0] floor_mid(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:1];
    endfunction

endpackage

// File: rtl/binary_search_ctrl_if.sv
// Player-answer and guess/status bundle between the game front end and the controller.
// The master issues start and answers, and the slave (the controller) returns guess and status.
interface binary_search_ctrl_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
);
    logic              start;
    logic              higher;
    logic              lower;
    logic              correct;
    logic [WIDTH-1:0]  guess;
    logic [STEP_W-1:0] steps;
    logic              busy;
    logic              done;
    logic              error;

    modport master (
        output start, higher, lower, correct,
        input  guess, steps, busy, done, error
    );

    modport slave (
        input  start, higher, lower, correct,
        output guess, steps, busy, done, error
    );
endinterface

// File: rtl/binary_search_ctrl_mid.sv
// Combinational floor((a+b)/2) for two 8-bit operands.
// The sum is formed at 9 bits, so it never overflows.
module binary_search_ctrl_mid
    import binary_search_ctrl_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] mid
);
    assign mid = floor_mid(a, b);
endmodule

// File: rtl/binary_search_ctrl.sv
// Binary-search controller for the guessing game.
// It holds [lo,hi], drives a registered guess (which feeds bin2bcd) and flags contradictory answers.
module binary_search_ctrl
    import binary_search_ctrl_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    binary_search_ctrl_if.slave  bus
);
    state_t            state_reg;
    logic [WIDTH-1:0]  lo_reg;
    logic [WIDTH-1:0]  hi_reg;
    logic [WIDTH-1:0]  guess_reg;
    logic [STEP_W-1:0] steps_reg;
    logic              busy_reg;
    logic              done_reg;
    logic              error_reg;

    // Slot 0 gives the next guess after "higher", and slot 1 gives it after "lower".
    logic [WIDTH-1:0] op_a  [2];
    logic [WIDTH-1:0] op_b  [2];
    logic [WIDTH-1:0] mid_y [2];

    assign op_a[0] = guess_reg + WIDTH'(1);
    assign op_b[0] = hi_reg;
    assign op_a[1] = lo_reg;
    assign op_b[1] = guess_reg - WIDTH'(1);

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_mid
            binary_search_ctrl_mid u_mid (
                .a   (op_a[gi]),
                .b   (op_b[gi]),
                .mid (mid_y[gi])
            );
        end
    endgenerate

    logic              answer_ok;
    logic [STEP_W-1:0] steps_inc;

    assign answer_ok = $onehot({bus.higher, bus.lower, bus.correct});
    assign steps_inc = (steps_reg == '1) ? steps_reg : steps_reg + STEP_W'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
            lo_reg    <= INIT_LO;
            hi_reg    <= INIT_HI;
            guess_reg <= '0;
            steps_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else if (bus.start) begin
            state_reg <= S_ASK;
            lo_reg    <= INIT_LO;
            hi_reg    <= INIT_HI;
            guess_reg <= INIT_GUESS;
            steps_reg <= '0;
            busy_reg  <= 1'b1;
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
        end else if (state_reg == S_ASK && answer_ok) begin
            // A guess sitting on the bound it would have to move past means the player contradicted an earlier answer.
            if (bus.higher) begin
                if (guess_reg == hi_reg) begin
                    state_reg <= S_ERR;
                    busy_reg  <= 1'b0;
                    error_reg <= 1'b1;
                end else begin
                    lo_reg    <= op_a[0];
                    guess_reg <= mid_y[0];
                    steps_reg <= steps_inc;
                end
            end else if (bus.lower) begin
                if (guess_reg == lo_reg) begin
                    state_reg <= S_ERR;
                    busy_reg  <= 1'b0;
                    error_reg <= 1'b1;
                end else begin
                    hi_reg    <= op_b[1];
                    guess_reg <= mid_y[1];
                    steps_reg <= steps_inc;
                end
            end else begin
                state_reg <= S_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
            end
        end
    end

    assign bus.guess = guess_reg;
    assign bus.steps = steps_reg;
    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.error = error_reg;
endmodule

// File: tb/tb_binary_search_ctrl.sv
// Scoreboard bench for binary_search_ctrl. Stimulus queues the expected outputs for the cycle after each input.
// A negedge monitor pops each entry and compares it with the DUT outputs.
module tb_binary_search_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    binary_search_ctrl_if #(.WIDTH(8), .STEP_W(4)) bus ();

    binary_search_ctrl #(.WIDTH(8), .STEP_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef logic [14:0] resp_t;   // {guess, steps, busy, done, error}

    int    checks   = 0;
    int    failures = 0;
    int    cyc      = 0;
    resp_t exp_q  [$];
    int    cyc_q  [$];
    string name_q [$];

    function automatic resp_t mk(input int g, input int s, input bit b, input bit d, input bit e);
        return {8'(g), 4'(s), b, d, e};
    endfunction

    function automatic resp_t dut_resp();
        return {bus.guess, bus.steps, bus.busy, bus.done, bus.error};
    endfunction

    task automatic compare(input string name, input resp_t act, input resp_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got guess=%0d steps=%0d busy=%0b done=%0b error=%0b, expected guess=%0d steps=%0d busy=%0b done=%0b error=%0b",
                     name, act[14:7], act[6:3], act[2], act[1], act[0],
                     exp[14:7], exp[6:3], exp[2], exp[1], exp[0]);
        end else begin
            $display("ok   %s: guess=%0d steps=%0d busy=%0b done=%0b error=%0b",
                     name, act[14:7], act[6:3], act[2], act[1], act[0]);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        while (cyc_q.size() > 0 && cyc_q[0] <= cyc) begin
            compare(name_q[0], dut_resp(), exp_q[0]);
            void'(cyc_q.pop_front());
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
        end
    end

    // This task is called at posedge+1. It drives the inputs for one cycle and expects the result after the next edge.
    task automatic step(input bit s, input bit h, input bit l, input bit c,
                        input string name, input resp_t exp);
        bus.start   = s;
        bus.higher  = h;
        bus.lower   = l;
        bus.correct = c;
        exp_q.push_back(exp);
        cyc_q.push_back(cyc + 1);
        name_q.push_back(name);
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.higher  = 1'b0;
        bus.lower   = 1'b0;
        bus.correct = 1'b0;
    endtask

    int up_guess [8] = '{191, 223, 239, 247, 251, 253, 254, 255};
    int dn_guess [7] = '{63, 31, 15, 7, 3, 1, 0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start   = 1'b0;
        bus.higher  = 1'b0;
        bus.lower   = 1'b0;
        bus.correct = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Check the reset state, and that answers are ignored in IDLE.
        step(0, 0, 0, 0, "reset_state", mk(0, 0, 0, 0, 0));
        step(0, 1, 0, 0, "idle_higher_ignored", mk(0, 0, 0, 0, 0));
        step(0, 0, 0, 1, "idle_correct_ignored", mk(0, 0, 0, 0, 0));

        // Basic game.
        step(1, 0, 0, 0, "t1_start", mk(127, 0, 1, 0, 0));
        step(0, 1, 0, 0, "t1_higher", mk(191, 1, 1, 0, 0));
        step(0, 0, 1, 0, "t1_lower", mk(159, 2, 1, 0, 0));
        step(0, 0, 0, 1, "t1_correct", mk(159, 2, 0, 1, 0));

        // Answers are ignored in DONE; start re-enters ASK.
        step(0, 1, 0, 0, "done_higher_ignored", mk(159, 2, 0, 1, 0));
        step(0, 0, 1, 0, "done_lower_ignored", mk(159, 2, 0, 1, 0));
        step(0, 0, 0, 1, "done_correct_ignored", mk(159, 2, 0, 1, 0));
        step(1, 0, 0, 0, "done_restart", mk(127, 0, 1, 0, 0));

        // Climb to the top bound, then give a contradictory higher.
        for (int i = 0; i < 8; i++)
            step(0, 1, 0, 0, $sformatf("t2_higher_%0d", i + 1), mk(up_guess[i], i + 1, 1, 0, 0));
        step(0, 1, 0, 0, "t2_higher_at_top", mk(255, 8, 0, 0, 1));
        step(0, 0, 1, 0, "err_lower_ignored", mk(255, 8, 0, 0, 1));
        step(0, 0, 0, 1, "err_correct_ignored", mk(255, 8, 0, 0, 1));
        step(1, 0, 0, 0, "err_restart", mk(127, 0, 1, 0, 0));

        // Descend to the bottom bound, then give a contradictory lower.
        for (int i = 0; i < 7; i++)
            step(0, 0, 1, 0, $sformatf("t3_lower_%0d", i + 1), mk(dn_guess[i], i + 1, 1, 0, 0));
        step(0, 0, 1, 0, "t3_lower_at_bottom", mk(0, 7, 0, 0, 1));

        // Non-onehot answers are ignored; start overrides a simultaneous answer.
        step(1, 0, 0, 0, "t4_start", mk(127, 0, 1, 0, 0));
        step(0, 1, 1, 0, "t4_higher_lower_ignored", mk(127, 0, 1, 0, 0));
        step(0, 1, 0, 1, "t4_higher_correct_ignored", mk(127, 0, 1, 0, 0));
        step(0, 1, 0, 0, "t4_higher", mk(191, 1, 1, 0, 0));
        step(1, 1, 0, 0, "t4_start_beats_higher", mk(127, 0, 1, 0, 0));

        // Back-to-back answers on consecutive cycles.
        step(0, 1, 0, 0, "t5_b2b_higher_1", mk(191, 1, 1, 0, 0));
        step(0, 1, 0, 0, "t5_b2b_higher_2", mk(223, 2, 1, 0, 0));
        step(0, 0, 1, 0, "t5_b2b_lower", mk(207, 3, 1, 0, 0));

        // Asynchronous reset between clock edges.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        compare("t5_async_reset", dut_resp(), mk(0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(0, 1, 0, 0, "post_reset_idle", mk(0, 0, 0, 0, 0));
        step(1, 0, 0, 0, "post_reset_start", mk(127, 0, 1, 0, 0));

        for (int i = 0; i < 10 && cyc_q.size() > 0; i++) @(posedge clk);
        if (cyc_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", cyc_q.size());
        end
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
